b13_rx_deframer: RTL and testbench

B13_RX_DEFRAMER -- requirements
Module: b13_rx_deframer

---
 rtl/b13_pkg.sv | 14 +
 rtl/b13_rx_deframer_if.sv | 27 ++
 rtl/b13_sync2.sv | 25 ++
 rtl/b13_rx_deframer.sv | 169 ++++++++++++++++
 tb/tb_b13_rx_deframer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/b13_pkg.sv
// Shared types and constants for the B13 serial receive deframer.
package b13_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int BIT_TICKS_DEF = 104;
    localparam int DATA_BITS     = 8;

endpackage

// File: rtl/b13_rx_deframer_if.sv
// Byte-side handshake of the deframer: data/valid/ready plus the two error pulses.
interface b13_rx_deframer_if;
    import b13_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/b13_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module b13_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Synchronizer stages, both forced to the idle level on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/b13_rx_deframer.sv
// UART-style receive deframer: start-edge detection, mid-bit sampling, stop check,
// and a one-deep output register with overrun reporting.
module b13_rx_deframer #(
    parameter int BIT_TICKS = b13_pkg::BIT_TICKS_DEF,
    parameter int DATA_BITS = b13_pkg::DATA_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      serial_in,
    b13_rx_deframer_if.master         rx_if,
    output logic                      busy
);
    import b13_pkg::*;

    localparam logic [6:0] HALF_TICK = 7'(BIT_TICKS / 2);
    localparam logic [6:0] LAST_TICK = 7'(BIT_TICKS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic       line_s;
    logic       line_prev_r;
    logic [1:0] flush_cnt_r;
    logic       fall_s;

    rx_state_t  state_r,   state_next_s;
    logic [6:0] tick_r,    tick_next_s;
    logic [2:0] bit_idx_r, bit_idx_next_s;
    logic [7:0] shift_r,   shift_next_s;
    logic       complete_s;
    logic       stop_err_s;

    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic       busy_r;

    b13_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (serial_in),
        .q     (line_s)
    );

    // Edge history; held at 0 until the synchronizer has flushed its reset value,
    // so a line still low after reset cannot look like a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cnt_r <= 2'd0;
            line_prev_r <= 1'b0;
        end else begin
            if (flush_cnt_r != 2'd2) begin
                flush_cnt_r <= flush_cnt_r + 2'd1;
            end
            line_prev_r <= (flush_cnt_r == 2'd2) ? line_s : 1'b0;
        end
    end

    assign fall_s = line_prev_r & ~line_s;

    // FSM state, tick counter, bit index and shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            tick_r    <= 7'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            tick_r    <= tick_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Next-state logic and bit sampling.
    always_comb begin
        state_next_s   = state_r;
        tick_next_s    = tick_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        complete_s     = 1'b0;
        stop_err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                bit_idx_next_s = 3'd0;
                // The detection cycle itself is tick 0, so the first START cycle is tick 1.
                if (fall_s) begin
                    state_next_s = START;
                    tick_next_s  = 7'd1;
                end else begin
                    state_next_s = IDLE;
                    tick_next_s  = 7'd0;
                end
            end
            START: begin
                if (tick_r == HALF_TICK) begin
                    tick_next_s = 7'd0;
                    if (!line_s) begin
                        state_next_s   = DATA;
                        bit_idx_next_s = 3'd0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    tick_next_s = tick_r + 7'd1;
                end
            end
            DATA: begin
                if (tick_r == LAST_TICK) begin
                    tick_next_s             = 7'd0;
                    shift_next_s[bit_idx_r] = line_s;
                    if (bit_idx_r == LAST_BIT) begin
                        state_next_s   = STOP;
                        bit_idx_next_s = 3'd0;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    tick_next_s = tick_r + 7'd1;
                end
            end
            STOP: begin
                if (tick_r == LAST_TICK) begin
                    tick_next_s  = 7'd0;
                    state_next_s = IDLE;
                    if (line_s) begin
                        complete_s = 1'b1;
                    end else begin
                        stop_err_s = 1'b1;
                    end
                end else begin
                    tick_next_s = tick_r + 7'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                tick_next_s  = 7'd0;
            end
        endcase
    end

    // Output register: load/consume handshake, error pulses and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= stop_err_s;
            overrun_r   <= complete_s & rx_valid_r & ~rx_if.rx_ready;
            busy_r      <= (state_next_s != IDLE);
            if (complete_s && (!rx_valid_r || rx_if.rx_ready)) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_if.rx_ready && !complete_s) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data   = rx_data_r;
    assign rx_if.rx_valid  = rx_valid_r;
    assign rx_if.frame_err = frame_err_r;
    assign rx_if.overrun   = overrun_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_b13_rx_deframer.sv
// Directed bench for b13_rx_deframer at BIT_TICKS=104: timing, glitch, framing, overrun, reset abort.
module tb_b13_rx_deframer;

    localparam int BT = 104;

    logic clock;
    logic reset;
    logic serial_in;
    logic rx_ready;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;

    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int vrise_cnt = 0;
    int vrise_cyc = 0;
    int brise_cyc = 0;
    int bfall_cyc = 0;
    logic valid_d = 1'b0;
    logic busy_d = 1'b0;

    b13_rx_deframer_if rx_if ();
    assign rx_if.rx_ready = rx_ready;

    b13_rx_deframer #(.BIT_TICKS(BT), .DATA_BITS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_if     (rx_if),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter: after posedge n has settled, cyc == n.
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor on the falling edge: pulse counts and rise/fall timestamps.
    always @(negedge clock) begin
        if (rx_if.frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_if.overrun) ov_cnt <= ov_cnt + 1;
        if (rx_if.frame_err && rx_if.overrun) both_cnt <= both_cnt + 1;
        if (rx_if.rx_valid && !valid_d) begin
            vrise_cnt <= vrise_cnt + 1;
            vrise_cyc <= cyc;
        end
        if (busy && !busy_d) brise_cyc <= cyc;
        if (!busy && busy_d) bfall_cyc <= cyc;
        valid_d <= rx_if.rx_valid;
        busy_d  <= busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; optionally raises
    // rx_ready for exactly the cycle ending at edge last_start+ready_at+1.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int ready_at);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        step(1);
        last_start = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int t = 0; t < BT; t++) begin
                if (b != 0 || t != 0) step(1);
                serial_in = bits[b];
                if (ready_at >= 0) rx_ready = ((cyc - last_start) == ready_at) ? 1'b1 : 1'b0;
            end
        end
        step(1);
        serial_in = 1'b1;
        if (ready_at >= 0) rx_ready = 1'b0;
    endtask

    initial begin
        int fe0, ov0, v0, p;
        logic [8:0] part;

        reset = 1'b1;
        serial_in = 1'b1;
        rx_ready = 1'b0;
        step(3);
        check_eq("reset_data", rx_if.rx_data, 32'h00);
        check_eq("reset_valid", rx_if.rx_valid, 32'd0);
        check_eq("reset_ferr", rx_if.frame_err, 32'd0);
        check_eq("reset_ovr", rx_if.overrun, 32'd0);
        check_eq("reset_busy", busy, 32'd0);
        reset = 1'b0;
        step(5);

        // 0xA5 with consumer ready: valid rises 2 (sync) + 989 edges after the line is driven low.
        rx_ready = 1'b1;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, -1);
        step(5);
        check_eq("a5_data", rx_if.rx_data, 32'hA5);
        check_eq("a5_latency", vrise_cyc - last_start, 32'd991);
        check_eq("a5_busy_rise", brise_cyc - last_start, 32'd3);
        check_eq("a5_consumed", rx_if.rx_valid, 32'd0);
        check_eq("a5_no_ferr", fe_cnt - fe0, 32'd0);

        // 10-cycle low glitch: START sample sees high, busy lasts 52 cycles.
        rx_ready = 1'b0;
        fe0 = fe_cnt;
        v0 = vrise_cnt;
        p = cyc;
        serial_in = 1'b0;
        step(10);
        serial_in = 1'b1;
        step(150);
        check_eq("glitch_busy_rise", brise_cyc - p, 32'd3);
        check_eq("glitch_busy_len", bfall_cyc - brise_cyc, 32'd52);
        check_eq("glitch_no_valid", vrise_cnt - v0, 32'd0);
        check_eq("glitch_no_ferr", fe_cnt - fe0, 32'd0);

        // 0x3C with a bad stop bit.
        fe0 = fe_cnt;
        v0 = vrise_cnt;
        send_frame(8'h3C, 1'b0, -1);
        step(5);
        check_eq("ferr_pulses", fe_cnt - fe0, 32'd1);
        check_eq("ferr_no_vrise", vrise_cnt - v0, 32'd0);
        check_eq("ferr_valid", rx_if.rx_valid, 32'd0);
        check_eq("ferr_data_kept", rx_if.rx_data, 32'hA5);

        // 0x11 then 0x22 with no consumer: second byte dropped.
        ov0 = ov_cnt;
        v0 = vrise_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        step(3);
        check_eq("ovr_data", rx_if.rx_data, 32'h11);
        check_eq("ovr_valid", rx_if.rx_valid, 32'd1);
        check_eq("ovr_pulses", ov_cnt - ov0, 32'd1);
        check_eq("ovr_vrise", vrise_cnt - v0, 32'd1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(2);
        check_eq("ovr_drain_valid", rx_if.rx_valid, 32'd0);
        check_eq("ovr_drain_data", rx_if.rx_data, 32'h11);

        // Consumer ready exactly in the completion cycle of 0x22.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, 990);
        step(3);
        check_eq("swap_data", rx_if.rx_data, 32'h22);
        check_eq("swap_valid", rx_if.rx_valid, 32'd1);
        check_eq("swap_no_ovr", ov_cnt - ov0, 32'd0);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(2);
        check_eq("swap_drain_valid", rx_if.rx_valid, 32'd0);

        // Reset during data bit 4 with the line left low.
        rx_ready = 1'b1;
        fe0 = fe_cnt;
        v0 = vrise_cnt;
        part = {8'hC3, 1'b0};
        step(1);
        for (int b = 0; b < 5; b++) begin
            serial_in = part[b];
            step(BT);
        end
        serial_in = part[5];
        step(50);
        reset = 1'b1;
        step(2);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_valid", rx_if.rx_valid, 32'd0);
        check_eq("rst_data", rx_if.rx_data, 32'h00);
        check_eq("rst_ferr", rx_if.frame_err, 32'd0);
        reset = 1'b0;
        step(300);
        check_eq("rst_low_busy", busy, 32'd0);
        check_eq("rst_low_no_vrise", vrise_cnt - v0, 32'd0);
        check_eq("rst_low_no_ferr", fe_cnt - fe0, 32'd0);
        serial_in = 1'b1;
        step(20);
        check_eq("rst_high_busy", busy, 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        step(3);
        check_eq("post_rst_data", rx_if.rx_data, 32'h5A);
        check_eq("post_rst_vrise", vrise_cnt - v0, 32'd1);

        check_eq("ferr_ovr_exclusive", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
